idct8: RTL and testbench

IDCT8 -- requirements
Module: idct8

---
 rtl/idct_pkg.sv | 32 +++
 rtl/idct_mac_unit.sv | 51 +++++
 rtl/idct8.sv | 115 +++++++++++
 tb/tb_idct8.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/idct_pkg.sv
// idct_pkg -- shared definitions for the 8-point inverse DCT block.
//   DATA_W_DEF / FRAC_BITS_DEF : default sample width and fixed-point shift
//   PROD_W / ACC_W             : product and accumulator widths
//   state_e                    : sequencer states (IDLE, CALC, DONE)
//   COS_TAB[n][k]              : round(128*c(k)*cos((2n+1)k*pi/16)),
//                                c(0)=1/sqrt(8), c(k>0)=1/2
package idct_pkg;

    localparam int DATA_W_DEF    = 8;
    localparam int FRAC_BITS_DEF = 7;
    localparam int PROD_W        = 16;
    // Worst-case row magnitude is 337*128, so 19 bits leaves ample headroom.
    localparam int ACC_W         = 19;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic signed [7:0] COS_TAB [0:7][0:7] = '{
        '{8'sd45,  8'sd63,  8'sd59,  8'sd53,  8'sd45,  8'sd36,  8'sd24,  8'sd12},
        '{8'sd45,  8'sd53,  8'sd24, -8'sd12, -8'sd45, -8'sd63, -8'sd59, -8'sd36},
        '{8'sd45,  8'sd36, -8'sd24, -8'sd63, -8'sd45,  8'sd12,  8'sd59,  8'sd53},
        '{8'sd45,  8'sd12, -8'sd59, -8'sd36,  8'sd45,  8'sd53, -8'sd24, -8'sd63},
        '{8'sd45, -8'sd12, -8'sd59,  8'sd36,  8'sd45, -8'sd53, -8'sd24,  8'sd63},
        '{8'sd45, -8'sd36, -8'sd24,  8'sd63, -8'sd45, -8'sd12,  8'sd59, -8'sd53},
        '{8'sd45, -8'sd53,  8'sd24,  8'sd12, -8'sd45,  8'sd63, -8'sd59,  8'sd36},
        '{8'sd45, -8'sd63,  8'sd59, -8'sd53,  8'sd45, -8'sd36,  8'sd24, -8'sd12}
    };

endpackage

// File: rtl/idct_mac_unit.sv
// idct_mac_unit -- combinational signed multiply-accumulate with output reduction.
//   x, c     : signed sample coefficient and cosine weight
//   clear    : start a new sum (ignore acc_in)
//   acc_in   : running accumulator
//   acc_out  : acc_in (or 0) + x*c
//   y_out    : acc_out >>> FRAC_BITS reduced to DATA_W
// Macro IDCT_SAT_EN: saturate the reduced output; otherwise wrap (keep low bits).
module idct_mac_unit
    import idct_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int FRAC_BITS = FRAC_BITS_DEF
) (
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] c,
    input  logic                     clear,
    input  logic signed [ACC_W-1:0]  acc_in,
    output logic signed [ACC_W-1:0]  acc_out,
    output logic signed [DATA_W-1:0] y_out
);

`ifdef IDCT_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 <<< (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - 1;
`endif

    function automatic logic signed [DATA_W-1:0] reduce_out(input logic signed [ACC_W-1:0] v);
`ifdef IDCT_SAT_EN
        if (v > SAT_MAX)
            return SAT_MAX[DATA_W-1:0];
        else if (v < SAT_MIN)
            return SAT_MIN[DATA_W-1:0];
        else
            return v[DATA_W-1:0];
`else
        return v[DATA_W-1:0];
`endif
    endfunction

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_base;

    always_comb begin
        prod     = PROD_W'(x) * PROD_W'(c);
        acc_base = clear ? '0 : acc_in;
        acc_out  = acc_base + ACC_W'(prod);
        // Arithmetic shift floors toward minus infinity for negative sums.
        y_out    = reduce_out(acc_out >>> FRAC_BITS);
    end

endmodule

// File: rtl/idct8.sv
// idct8 -- 8-point inverse DCT, one multiply-accumulate per cycle (64 cycles).
//   clk, reset : clock, synchronous active-high reset
//   wr/add/data_in : write coefficient X[add] (ignored while busy)
//   start      : begin a transform (ignored unless idle)
//   oe/add     : read sample Y[add] onto data_out one cycle later (0 when oe=0)
//   busy       : high during the 64 CALC cycles
//   done       : one-cycle pulse after the last sample is written
// Macro IDCT_SAT_EN: saturate outputs instead of wrapping (see idct_mac_unit).
module idct8
    import idct_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int FRAC_BITS = FRAC_BITS_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr,
    input  logic [2:0]               add,
    input  logic signed [DATA_W-1:0] data_in,
    input  logic                     start,
    input  logic                     oe,
    output logic signed [DATA_W-1:0] data_out,
    output logic                     busy,
    output logic                     done
);

    state_e                    state_q, state_d;
    logic [2:0]                k_q, k_d;
    logic [2:0]                n_q, n_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [DATA_W-1:0]  x_q [8];
    logic signed [DATA_W-1:0]  x_d [8];
    logic signed [DATA_W-1:0]  y_q [8];
    logic signed [DATA_W-1:0]  y_d [8];
    logic signed [DATA_W-1:0]  data_out_q, data_out_d;

    logic signed [ACC_W-1:0]   mac_acc;
    logic signed [DATA_W-1:0]  mac_y;

    idct_mac_unit #(
        .DATA_W    (DATA_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_mac (
        .x       (x_q[k_q]),
        .c       (DATA_W'(COS_TAB[n_q][k_q])),
        .clear   (k_q == 3'd0),
        .acc_in  (acc_q),
        .acc_out (mac_acc),
        .y_out   (mac_y)
    );

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        n_d        = n_q;
        acc_d      = acc_q;
        x_d        = x_q;
        y_d        = y_q;
        data_out_d = oe ? y_q[add] : '0;

        // A write alongside start lands before the first MAC reads X.
        if (wr && state_q != ST_CALC)
            x_d[add] = data_in;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CALC;
                    k_d     = 3'd0;
                    n_d     = 3'd0;
                    acc_d   = '0;
                end
            end
            ST_CALC: begin
                acc_d = mac_acc;
                k_d   = k_q + 3'd1;
                if (k_q == 3'd7) begin
                    y_d[n_q] = mac_y;
                    n_d      = n_q + 3'd1;
                    if (n_q == 3'd7)
                        state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            n_q        <= '0;
            acc_q      <= '0;
            data_out_q <= '0;
            for (int i = 0; i < 8; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            n_q        <= n_d;
            acc_q      <= acc_d;
            data_out_q <= data_out_d;
            x_q        <= x_d;
            y_q        <= y_d;
        end
    end

    assign data_out = data_out_q;
    assign busy     = (state_q == ST_CALC);
    assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_idct8.sv
// tb_idct8 -- self-checking bench for idct8 with a real-arithmetic IDCT model.
module tb_idct8;

    logic       clk = 1'b0;
    logic       reset, wr, start, oe;
    logic [2:0] add;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       busy, done;

    always #5 clk = ~clk;

    idct8 dut (
        .clk      (clk),
        .reset    (reset),
        .wr       (wr),
        .add      (add),
        .data_in  (data_in),
        .start    (start),
        .oe       (oe),
        .data_out (data_out),
        .busy     (busy),
        .done     (done)
    );

    int         checks   = 0;
    int         failures = 0;
    int         cos_tab [8][8];
    int         ref_x [8];
    logic [7:0] ref_y [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic build_table();
        real pi, ck;
        pi = 3.14159265358979;
        for (int n = 0; n < 8; n++)
            for (int k = 0; k < 8; k++) begin
                ck = (k == 0) ? 1.0 / $sqrt(8.0) : 0.5;
                cos_tab[n][k] = int'($floor(128.0 * ck * $cos((2 * n + 1) * k * pi / 16.0) + 0.5));
            end
    endtask

    task automatic model();
        int sum, sh;
        for (int n = 0; n < 8; n++) begin
            sum = 0;
            for (int k = 0; k < 8; k++)
                sum += ref_x[k] * cos_tab[n][k];
            sh = sum >>> 7;
`ifdef IDCT_SAT_EN
            if (sh > 127) sh = 127;
            if (sh < -128) sh = -128;
`endif
            ref_y[n] = 8'(sh);
        end
    endtask

    task automatic load_all();
        for (int k = 0; k < 8; k++) begin
            wr = 1'b1; add = 3'(k); data_in = 8'(ref_x[k]);
            tick();
        end
        wr = 1'b0;
    endtask

    task automatic read_y(input int idx, output logic [7:0] v);
        add = 3'(idx); oe = 1'b1;
        tick();
        v  = data_out;
        oe = 1'b0;
    endtask

    task automatic check_all_y(input string tag);
        logic [7:0] v;
        for (int n = 0; n < 8; n++) begin
            read_y(n, v);
            check($sformatf("%s_y%0d", tag, n), 32'(v), 32'(ref_y[n]));
        end
        tick();
        check($sformatf("%s_oe0", tag), 32'(data_out), 32'd0);
    endtask

    // Pulses start, then watches 100 cycles; optional disturbances at given cycles.
    task automatic run(input int wr_at, input int start_at, input int rst_at,
                       output int busy_cnt, output int done_cnt, output int done_at);
        start = 1'b1;
        tick();
        start = 1'b0; wr = 1'b0;
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        for (int c = 1; c <= 100; c++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            if (c == wr_at) begin wr = 1'b1; add = 3'd3; data_in = 8'd5; end
            if (c == start_at) start = 1'b1;
            if (c == rst_at) reset = 1'b1;
            tick();
            wr = 1'b0; start = 1'b0; reset = 1'b0;
        end
    endtask

    initial begin
        int         bc, dc, da;
        logic [7:0] v;

        reset = 1'b1; wr = 1'b0; start = 1'b0; oe = 1'b0; add = 3'd0; data_in = 8'd0;
        build_table();
        for (int k = 0; k < 8; k++) ref_x[k] = 0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dout", 32'(data_out), 32'd0);

        // First cycle after reset release: write X[0]=64 and read Y[0].
        reset = 1'b0; wr = 1'b1; add = 3'd0; data_in = 8'd64; oe = 1'b1;
        tick();
        wr = 1'b0; oe = 1'b0;
        check("rst_y0", 32'(data_out), 32'd0);
        ref_x[0] = 64;
        run(-1, -1, -1, bc, dc, da);
        check("dc_busy", 32'(bc), 32'd64);
        check("dc_done_cnt", 32'(dc), 32'd1);
        check("dc_done_at", 32'(da), 32'd65);
        for (int n = 0; n < 8; n++) begin
            read_y(n, v);
            check($sformatf("dc64_y%0d", n), 32'(v), 32'h16);
        end

        for (int k = 0; k < 8; k++) ref_x[k] = 0;
        ref_x[0] = -128;
        load_all();
        run(-1, -1, -1, bc, dc, da);
        for (int n = 0; n < 8; n++) begin
            read_y(n, v);
            check($sformatf("dcneg_y%0d", n), 32'(v), 32'hD3);
        end

        for (int k = 0; k < 8; k++) ref_x[k] = 0;
        ref_x[1] = 64;
        load_all();
        run(-1, -1, -1, bc, dc, da);
        check("x1_busy", 32'(bc), 32'd64);
        read_y(0, v);
        check("x1_y0", 32'(v), 32'd31);
        read_y(7, v);
        check("x1_y7", 32'(v), 32'hE0);
        model();
        check_all_y("x1");

        for (int k = 0; k < 8; k++) ref_x[k] = 127;
        load_all();
        run(-1, -1, -1, bc, dc, da);
        read_y(0, v);
`ifdef IDCT_SAT_EN
        check("max_y0", 32'(v), 32'd127);
`else
        check("max_y0", 32'(v), 32'h4E);
`endif
        model();
        check_all_y("max");

        // Write and second start while busy must both be ignored.
        for (int k = 0; k < 8; k++) ref_x[k] = int'($signed(8'($urandom_range(0, 255))));
        load_all();
        run(10, 20, -1, bc, dc, da);
        check("ign_busy", 32'(bc), 32'd64);
        check("ign_done_cnt", 32'(dc), 32'd1);
        model();
        check_all_y("ign");

        // Random transforms; the last coefficient write shares the cycle with start.
        for (int it = 0; it < 3; it++) begin
            for (int k = 0; k < 8; k++) ref_x[k] = int'($signed(8'($urandom_range(0, 255))));
            for (int k = 0; k < 7; k++) begin
                wr = 1'b1; add = 3'(k); data_in = 8'(ref_x[k]);
                tick();
            end
            wr = 1'b1; add = 3'd7; data_in = 8'(ref_x[7]);
            run(-1, -1, -1, bc, dc, da);
            check($sformatf("rnd%0d_done_at", it), 32'(da), 32'd65);
            model();
            check_all_y($sformatf("rnd%0d", it));
        end

        // Reset in the middle of CALC aborts with no done and clears X and Y.
        for (int k = 0; k < 8; k++) ref_x[k] = int'($signed(8'($urandom_range(0, 255))));
        load_all();
        run(-1, -1, 10, bc, dc, da);
        check("abort_done_cnt", 32'(dc), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 8; k++) ref_x[k] = 0;
        model();
        check_all_y("abort");
        run(-1, -1, -1, bc, dc, da);
        check("post_done_at", 32'(da), 32'd65);
        check_all_y("post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
